// File: rtl/game_flow_fsm.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_fsm
// Purpose  : Screen-flow controller (START/SERVE/GAME/PAUSE/OVER) with tick
//            prescaler, score keeping and a one-cycle game-logic clear pulse.
//            Define GAME_FLOW_SERVE_DELAY_EN to include the SERVE delay state.
// Revision : 1.0 - initial release
// ============================================================================
module game_flow_fsm #(
  parameter int TICK_DIV  = 4,
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 7,
  parameter int SEL_W     = 2,
  parameter int SERVE_CYC = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enter,
  input  logic [SEL_W-1:0]   menu_sel,
  input  logic               point_a,
  input  logic               point_b,
  output logic               tick_game,
  output logic               tick_menu,
  output logic               enable_start,
  output logic               enable_game,
  output logic               enable_pause,
  output logic               enable_over,
  output logic               enable_serve,
  output logic               game_reset_n,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               winner
);

  localparam int                 c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0]    c_TICK_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] c_WIN       = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_SERVE = 3'd1,
    ST_GAME  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

`ifdef GAME_FLOW_SERVE_DELAY_EN
  localparam int              c_SW         = $clog2(SERVE_CYC + 1);
  localparam logic [c_SW-1:0] c_SERVE_LAST = c_SW'(SERVE_CYC - 1);
  // Every new rally begins with the serve delay.
  localparam state_t          c_ENTRY      = ST_SERVE;
`else
  localparam state_t          c_ENTRY      = ST_GAME;
`endif

  // Parameter sanity hook: an illegal configuration leaves a visible empty scope.
  if (TICK_DIV < 1 || WIN_SCORE < 1 || SERVE_CYC < 1) begin : g_bad_params
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_enter_q;
  logic [c_PW-1:0]    r_presc;
  logic [c_PW-1:0]    w_presc_nxt;
  logic               w_strobe_nxt;
  logic               w_enter_rise;
  logic [SCORE_W-1:0] r_score_a;
  logic [SCORE_W-1:0] r_score_b;
  logic [SCORE_W-1:0] w_score_a_nxt;
  logic [SCORE_W-1:0] w_score_b_nxt;
  logic [SCORE_W-1:0] w_inc_a;
  logic [SCORE_W-1:0] w_inc_b;
  logic               r_winner;
  logic               w_winner_nxt;
  logic               w_clear;
  logic               w_nxt_play;
  logic               w_nxt_menu;
  logic               r_game_reset_n;
  logic               r_tick_game;
  logic               r_tick_menu;
  logic               r_en_start;
  logic               r_en_game;
  logic               r_en_pause;
  logic               r_en_over;
`ifdef GAME_FLOW_SERVE_DELAY_EN
  logic [c_SW-1:0]    r_serve_cnt;
  logic [c_SW-1:0]    w_serve_cnt_nxt;
  logic               r_from_serve;
  logic               w_from_serve_nxt;
  logic               r_en_serve;
`endif

  always_comb begin
    w_enter_rise = enter & ~r_enter_q;
    w_presc_nxt  = (r_presc == c_TICK_LAST) ? '0 : r_presc + c_PW'(1);
    w_strobe_nxt = (w_presc_nxt == c_TICK_LAST);
    w_inc_a      = (r_score_a == c_WIN) ? r_score_a : r_score_a + SCORE_W'(1);
    w_inc_b      = (r_score_b == c_WIN) ? r_score_b : r_score_b + SCORE_W'(1);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_score_a_nxt = r_score_a;
    w_score_b_nxt = r_score_b;
    w_winner_nxt  = r_winner;
    w_clear       = 1'b0;
`ifdef GAME_FLOW_SERVE_DELAY_EN
    w_serve_cnt_nxt  = r_serve_cnt;
    w_from_serve_nxt = r_from_serve;
`endif

    case (r_state)
      ST_START: begin
        if (w_enter_rise) begin
          w_state_nxt = c_ENTRY;
          w_clear     = 1'b1;
        end
      end

`ifdef GAME_FLOW_SERVE_DELAY_EN
      ST_SERVE: begin
        // Completing the delay wins over a coincident pause request.
        if (r_tick_game && (r_serve_cnt == c_SERVE_LAST)) begin
          w_state_nxt     = ST_GAME;
          w_serve_cnt_nxt = '0;
        end else begin
          if (r_tick_game) begin
            w_serve_cnt_nxt = r_serve_cnt + c_SW'(1);
          end
          if (w_enter_rise) begin
            w_state_nxt      = ST_PAUSE;
            w_from_serve_nxt = 1'b1;
          end
        end
      end
`endif

      ST_GAME: begin
        if (point_a ^ point_b) begin
          if (point_a) begin
            w_score_a_nxt = w_inc_a;
            if (w_inc_a == c_WIN) begin
              w_state_nxt  = ST_OVER;
              w_winner_nxt = 1'b0;
            end else begin
              w_state_nxt = c_ENTRY;
            end
          end else begin
            w_score_b_nxt = w_inc_b;
            if (w_inc_b == c_WIN) begin
              w_state_nxt  = ST_OVER;
              w_winner_nxt = 1'b1;
            end else begin
              w_state_nxt = c_ENTRY;
            end
          end
`ifdef GAME_FLOW_SERVE_DELAY_EN
          w_serve_cnt_nxt = '0;
`endif
        end else if (w_enter_rise && !(point_a && point_b)) begin
          w_state_nxt = ST_PAUSE;
`ifdef GAME_FLOW_SERVE_DELAY_EN
          w_from_serve_nxt = 1'b0;
`endif
        end
      end

      ST_PAUSE: begin
        if (w_enter_rise) begin
          if (menu_sel == '0) begin
`ifdef GAME_FLOW_SERVE_DELAY_EN
            w_state_nxt = r_from_serve ? ST_SERVE : ST_GAME;
`else
            w_state_nxt = ST_GAME;
`endif
          end else if (menu_sel == SEL_W'(1)) begin
            w_state_nxt = ST_START;
            w_clear     = 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (w_enter_rise) begin
          w_state_nxt = ST_START;
        end
      end

      default: begin
        w_state_nxt = ST_START;
      end
    endcase

    // A new match or a restart wipes everything the previous match left behind.
    if (w_clear) begin
      w_score_a_nxt = '0;
      w_score_b_nxt = '0;
      w_winner_nxt  = 1'b0;
`ifdef GAME_FLOW_SERVE_DELAY_EN
      w_serve_cnt_nxt = '0;
`endif
    end

    w_nxt_play = (w_state_nxt == ST_GAME) || (w_state_nxt == ST_SERVE);
    w_nxt_menu = (w_state_nxt == ST_START) || (w_state_nxt == ST_PAUSE) ||
                 (w_state_nxt == ST_OVER);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_START;
      r_enter_q      <= 1'b1;
      r_presc        <= '0;
      r_score_a      <= '0;
      r_score_b      <= '0;
      r_winner       <= 1'b0;
      r_game_reset_n <= 1'b0;
      r_tick_game    <= 1'b0;
      r_tick_menu    <= 1'b0;
      r_en_start     <= 1'b1;
      r_en_game      <= 1'b0;
      r_en_pause     <= 1'b0;
      r_en_over      <= 1'b0;
`ifdef GAME_FLOW_SERVE_DELAY_EN
      r_serve_cnt    <= '0;
      r_from_serve   <= 1'b0;
      r_en_serve     <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_enter_q      <= enter;
      r_presc        <= w_presc_nxt;
      r_score_a      <= w_score_a_nxt;
      r_score_b      <= w_score_b_nxt;
      r_winner       <= w_winner_nxt;
      r_game_reset_n <= ~w_clear;
      // Outputs are decoded from next state so they line up with r_state.
      r_tick_game    <= w_strobe_nxt & w_nxt_play;
      r_tick_menu    <= w_strobe_nxt & w_nxt_menu;
      r_en_start     <= (w_state_nxt == ST_START);
      r_en_game      <= (w_state_nxt == ST_GAME);
      r_en_pause     <= (w_state_nxt == ST_PAUSE);
      r_en_over      <= (w_state_nxt == ST_OVER);
`ifdef GAME_FLOW_SERVE_DELAY_EN
      r_serve_cnt    <= w_serve_cnt_nxt;
      r_from_serve   <= w_from_serve_nxt;
      r_en_serve     <= (w_state_nxt == ST_SERVE);
`endif
    end
  end

  assign tick_game    = r_tick_game;
  assign tick_menu    = r_tick_menu;
  assign enable_start = r_en_start;
  assign enable_game  = r_en_game;
  assign enable_pause = r_en_pause;
  assign enable_over  = r_en_over;
  assign game_reset_n = r_game_reset_n;
  assign score_a      = r_score_a;
  assign score_b      = r_score_b;
  assign winner       = r_winner;
`ifdef GAME_FLOW_SERVE_DELAY_EN
  assign enable_serve = r_en_serve;
`else
  assign enable_serve = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_flow_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_flow_fsm
// Purpose  : Directed self-checking bench for game_flow_fsm with a per-cycle
//            behavioural model; follows GAME_FLOW_SERVE_DELAY_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_flow_fsm;

  localparam int TICK_DIV  = 4;
  localparam int SCORE_W   = 4;
  localparam int WIN_SCORE = 7;
  localparam int SEL_W     = 2;
  localparam int SERVE_CYC = 8;
`ifdef GAME_FLOW_SERVE_DELAY_EN
  localparam bit SERVE_EN = 1'b1;
`else
  localparam bit SERVE_EN = 1'b0;
`endif
  localparam int S_START = 0, S_SERVE = 1, S_GAME = 2, S_PAUSE = 3, S_OVER = 4;
  localparam int VW = 9 + 2 * SCORE_W;

  logic               clock = 1'b0;
  logic               reset;
  logic               enter;
  logic [SEL_W-1:0]   menu_sel;
  logic               point_a;
  logic               point_b;
  logic               tick_game;
  logic               tick_menu;
  logic               enable_start;
  logic               enable_game;
  logic               enable_pause;
  logic               enable_over;
  logic               enable_serve;
  logic               game_reset_n;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               winner;

  int checks = 0;
  int errors = 0;

  game_flow_fsm #(
    .TICK_DIV (TICK_DIV),
    .SCORE_W  (SCORE_W),
    .WIN_SCORE(WIN_SCORE),
    .SEL_W    (SEL_W),
    .SERVE_CYC(SERVE_CYC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enter       (enter),
    .menu_sel    (menu_sel),
    .point_a     (point_a),
    .point_b     (point_b),
    .tick_game   (tick_game),
    .tick_menu   (tick_menu),
    .enable_start(enable_start),
    .enable_game (enable_game),
    .enable_pause(enable_pause),
    .enable_over (enable_over),
    .enable_serve(enable_serve),
    .game_reset_n(game_reset_n),
    .score_a     (score_a),
    .score_b     (score_b),
    .winner      (winner)
  );

  always #5 clock = ~clock;

  // Model: screen id, integer scores, and clocks elapsed since reset release.
  int m_scr        = S_START;
  int m_a          = 0;
  int m_b          = 0;
  int m_k          = 0;
  int m_serve      = 0;
  bit m_win        = 1'b0;
  bit m_from_serve = 1'b0;
  bit m_prev_enter = 1'b1;
  bit m_grn        = 1'b0;

  function automatic bit m_playing();
    return (m_scr == S_SERVE) || (m_scr == S_GAME);
  endfunction

  function automatic bit m_strobe();
    return (m_k % TICK_DIV) == (TICK_DIV - 1);
  endfunction

  task automatic model_clear();
    m_a = 0; m_b = 0; m_win = 1'b0; m_serve = 0; m_grn = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    bit tick_now;
    int nxt;
    if (!reset) begin
      m_scr = S_START; m_a = 0; m_b = 0; m_k = 0; m_serve = 0;
      m_win = 1'b0; m_from_serve = 1'b0; m_prev_enter = 1'b1; m_grn = 1'b0;
      return;
    end
    rise         = enter && !m_prev_enter;
    m_prev_enter = enter;
    tick_now     = m_strobe() && m_playing();
    m_grn        = 1'b1;
    nxt          = m_scr;
    case (m_scr)
      S_START: if (rise) begin nxt = SERVE_EN ? S_SERVE : S_GAME; model_clear(); end
      S_SERVE: begin
        if (tick_now) m_serve++;
        if (m_serve == SERVE_CYC) begin nxt = S_GAME; m_serve = 0; end
        else if (rise) begin nxt = S_PAUSE; m_from_serve = 1'b1; end
      end
      S_GAME: begin
        if (point_a != point_b) begin
          if (point_a) m_a++; else m_b++;
          if (m_a == WIN_SCORE) begin nxt = S_OVER; m_win = 1'b0; end
          else if (m_b == WIN_SCORE) begin nxt = S_OVER; m_win = 1'b1; end
          else begin nxt = SERVE_EN ? S_SERVE : S_GAME; m_serve = 0; end
        end else if (rise && !(point_a && point_b)) begin
          nxt = S_PAUSE; m_from_serve = 1'b0;
        end
      end
      S_PAUSE: if (rise) begin
        if (menu_sel == 0) nxt = m_from_serve ? S_SERVE : S_GAME;
        else if (menu_sel == 1) begin nxt = S_START; model_clear(); end
      end
      S_OVER: if (rise) nxt = S_START;
      default: nxt = S_START;
    endcase
    m_scr = nxt;
    m_k++;
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [VW-1:0] act;
    logic [VW-1:0] exp;
    @(negedge clock);
    act = {enable_start, enable_serve, enable_game, enable_pause, enable_over,
           tick_game, tick_menu, game_reset_n, winner, score_a, score_b};
    exp = {m_scr == S_START, m_scr == S_SERVE, m_scr == S_GAME, m_scr == S_PAUSE,
           m_scr == S_OVER, reset && m_strobe() && m_playing(),
           reset && m_strobe() && !m_playing(), m_grn, m_win,
           SCORE_W'(m_a), SCORE_W'(m_b)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_compare @%0t: got %b want %b", $time, act, exp);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press();
    step();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic point(input bit a, input bit b);
    point_a = a;
    point_b = b;
    step();
    point_a = 1'b0;
    point_b = 1'b0;
  endtask

  task automatic wait_game(input string name);
    int n = 0;
    while (enable_game !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check(name, enable_game, 1);
  endtask

  task automatic count_ticks(input int n, output int g, output int m);
    g = 0;
    m = 0;
    repeat (n) begin
      step();
      g += int'(tick_game);
      m += int'(tick_menu);
    end
  endtask

`ifdef GAME_FLOW_SERVE_DELAY_EN
  task automatic serve_pause_test();
    int s = 0;
    int n = 0;
    while (n < 100) begin
      if (tick_game) s++;
      if (s == 5) break;
      step();
      n++;
    end
    check("serve_five_strobes", s, 5);
    press();
    check("serve_pause", enable_pause, 1);
    menu_sel = '0;
    press();
    check("serve_resume", enable_serve, 1);
    s = 0;
    n = 0;
    while (enable_serve && n < 100) begin
      if (tick_game) s++;
      step();
      n++;
    end
    check("serve_remaining_strobes", s, 3);
    check("serve_done_game", enable_game, 1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int m;
    reset    = 1'b0;
    enter    = 1'b1;
    menu_sel = '0;
    point_a  = 1'b0;
    point_b  = 1'b0;
    repeat (3) step();
    check("reset_enable_start", enable_start, 1);
    check("reset_game_reset_n", game_reset_n, 0);
    check("reset_ticks", {tick_game, tick_menu}, 0);

    // Release with the button already held: no transition expected.
    reset = 1'b1;
    repeat (6) step();
    check("held_enter_stays_start", enable_start, 1);
    check("release_game_reset_n", game_reset_n, 1);
    enter = 1'b0;
    press();
    check("start_clear_pulse", game_reset_n, 0);
    check("start_to_play", SERVE_EN ? enable_serve : enable_game, 1);
    check("start_scores", {score_a, score_b}, 0);
    step();
    check("clear_pulse_one_cycle", game_reset_n, 1);
`ifdef GAME_FLOW_SERVE_DELAY_EN
    serve_pause_test();
`endif
    wait_game("enter_game");

    count_ticks(8, g, m);
    check("game_tick_game", g, 2);
    check("game_tick_menu", m, 0);

    point(1'b1, 1'b0);
    check("point_a_scores", score_a, 1);
    wait_game("after_point_a");
    point(1'b1, 1'b1);
    check("both_points_a", score_a, 1);
    check("both_points_b", score_b, 0);
    check("both_points_stay", enable_game, 1);

    press();
    check("pause_enter", enable_pause, 1);
    count_ticks(8, g, m);
    check("pause_tick_game", g, 0);
    check("pause_tick_menu", m, 2);
    menu_sel = 2'd2;
    press();
    check("menu_other_stays", enable_pause, 1);
    menu_sel = 2'd0;
    press();
    check("menu_continue", enable_game, 1);
    check("continue_keeps_score", score_a, 1);

    // Point and enter rise in the same cycle: the point wins.
    step();
    point_b = 1'b1;
    enter   = 1'b1;
    step();
    point_b = 1'b0;
    check("point_beats_enter_score", score_b, 1);
    check("point_beats_enter_no_pause", enable_pause, 0);
    step();
    enter = 1'b0;
    wait_game("after_coincide");

    press();
    check("pause_for_restart", enable_pause, 1);
    menu_sel = 2'd1;
    press();
    check("restart_start", enable_start, 1);
    check("restart_scores", {score_a, score_b}, 0);
    check("restart_clear_pulse", game_reset_n, 0);
    menu_sel = 2'd0;

    press();
    wait_game("new_match");
    for (int i = 0; i < 7; i++) begin
      point(1'b0, 1'b1);
      if (i < 6) wait_game("between_points");
    end
    check("win_over", enable_over, 1);
    check("win_score_b", score_b, 7);
    check("win_score_a", score_a, 0);
    check("win_winner", winner, 1);
    point(1'b0, 1'b1);
    check("over_ignores_point", score_b, 7);
    press();
    check("over_to_start", enable_start, 1);
    check("start_holds_score", score_b, 7);
    check("start_holds_winner", winner, 1);
    press();
    wait_game("rematch");
    check("rematch_scores", {score_a, score_b}, 0);
    check("rematch_winner", winner, 0);

    point(1'b1, 1'b0);
    wait_game("pre_reset_game");
    // Assert reset between edges; outputs must clear without a clock.
    #2 reset = 1'b0;
    #1;
    check("async_start", enable_start, 1);
    check("async_game", enable_game, 0);
    check("async_score", score_a, 0);
    check("async_grn", game_reset_n, 0);
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
    check("post_reset_start", enable_start, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_flow_fsm.md
GAME_FLOW_FSM -- requirements
Module: game_flow_fsm

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles between tick strobes (>=1).
REQ-002 Parameter SCORE_W, default 4, width of each score counter.
REQ-003 Parameter WIN_SCORE, default 7, score that ends a match (1..2^SCORE_W-1).
REQ-004 Parameter SEL_W, default 2, width of menu selection input.
REQ-005 Parameter SERVE_CYC, default 8, serve-delay length in game ticks.
REQ-006 clock  in  1  single system clock, all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 enter  in  1  joystick button, level, synchronous to clock.
REQ-009 menu_sel  in  SEL_W  pause menu item: 0 = continue, 1 = restart, others = no action.
REQ-010 point_a / point_b  in  1 each  one-cycle pulse: player A / B scored.
REQ-011 tick_game / tick_menu  out  1 each  one-cycle enable strobe to game / menu logic.
REQ-012 enable_start, enable_game, enable_pause, enable_over, enable_serve  out  1 each  one-hot screen enables.
REQ-013 game_reset_n  out  1  active-low one-cycle clear pulse to game logic.
REQ-014 score_a, score_b  out  SCORE_W each  current scores; winner  out  1  0 = A, 1 = B, valid in OVER.

Function
REQ-015 States: START, SERVE, GAME, PAUSE, OVER; registered Moore outputs; exactly one enable_* high, matching the state.
REQ-016 enter is edge-detected internally; only a 0->1 transition (enter_rise) triggers a transition; a held button acts once.
REQ-017 Prescaler counts 0..TICK_DIV-1 continuously; strobe is high for one cycle at terminal count; tick_game = strobe in SERVE/GAME, tick_menu = strobe in START/PAUSE/OVER, else 0.
REQ-018 START: enter_rise -> SERVE; scores cleared and game_reset_n low for exactly one cycle on that transition.
REQ-019 SERVE: counts SERVE_CYC tick_game strobes, then -> GAME; enter_rise -> PAUSE (serve count retained).
REQ-020 GAME: enter_rise -> PAUSE; a point pulse increments that player's score; reaching WIN_SCORE -> OVER with winner set, else -> SERVE.
REQ-021 point_a and point_b in the same cycle: both ignored, no score change, no transition.
REQ-022 Point pulses are ignored outside GAME; enter_rise coinciding with a point in GAME: point takes priority, enter ignored.
REQ-023 PAUSE: enter_rise with menu_sel=0 -> state paused from (GAME or SERVE); menu_sel=1 -> START with scores cleared and one-cycle game_reset_n low; other values: stay.
REQ-024 OVER: enter_rise -> START; scores and winner held until leaving START.
REQ-025 Score counters never wrap: saturate at WIN_SCORE.
REQ-026 Unreachable state encodings recover to START on the next clock.

Reset
REQ-027 While reset low: state START, prescaler 0, serve count 0, scores 0, winner 0, enter edge register 1 (a button held at release does not trigger), enable_start 1, other enables 0, ticks 0, game_reset_n 0.
REQ-028 First clock after reset release: game_reset_n 1; reset mid-match aborts immediately to the values above.

Configuration
REQ-029 Macro GAME_FLOW_SERVE_DELAY_EN: defined -> SERVE state and serve counter present as above.
REQ-030 Undefined -> SERVE omitted, enable_serve tied 0, transitions to SERVE go directly to GAME, SERVE_CYC unused.

Verification
REQ-031 Reset release, enter held high -> stays START; release then press -> SERVE, game_reset_n low for 1 cycle, scores 0.
REQ-032 TICK_DIV=4, in GAME -> tick_game high one cycle every 4 clocks, tick_menu 0; in PAUSE the reverse.
REQ-033 SERVE_CYC=8 -> GAME entered after 8th tick_game strobe; pause at 5th strobe, continue -> GAME after 3 more.
REQ-034 WIN_SCORE=7, seven point_b pulses in GAME -> OVER, winner=1, score_b=7; simultaneous point_a+point_b -> scores unchanged.
REQ-035 PAUSE with menu_sel=1 and enter pulse -> START, scores 0, game_reset_n low 1 cycle; menu_sel=2 -> stays PAUSE.
REQ-036 reset asserted mid-GAME asynchronously (between clock edges) -> outputs reach reset values without a clock edge.
